mult_div_hilo: RTL and testbench
================================

# mult_div_hilo

Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS core. It sits in the execute stage directly downstream of the register file. It takes the register-file read data (RS, RT) for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and produces the HI/LO values read by MFHI and MFLO. It processes one bit per cycle and drives a busy signal that the pipeline control uses to stall.

## Interface
- NBITS, 32, operand and HI/LO width

- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_start  in  1  start the operation selected by i_op; sampled only in IDLE
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_RS  in  NBITS  multiplicand / dividend; also the MTHI/MTLO data
- i_RT  in  NBITS  multiplier / divisor
- i_MTHI  in  1  write i_RS to HI
- i_MTLO  in  1  write i_RS to LO
- o_HI  out  NBITS  architectural HI
- o_LO  out  NBITS  architectural LO
- o_busy  out  1  high whenever state is not IDLE
- o_done  out  1  one-cycle pulse on the cycle after HI/LO commit
- o_div_zero  out  1  one-cycle pulse, coincident with o_done, for divide by zero

## Operation
- States:
  - IDLE: wait for i_start.
  - CALC: NBITS iterations, counter NBITS-1 down to 0.
  - FIX: sign correction and commit of HI/LO.
- IDLE plus i_start: latch i_op; store abs(i_RS) and abs(i_RT) for signed ops, raw values for unsigned ops; record the result signs; go to CALC.
- Multiply:
  - Shift-add on a 2·NBITS accumulator.
  - Signed product = negated unsigned product when the operand signs differ.
  - Result: HI = product[2N-1:N], LO = product[N-1:0].
- Divide:
  - Restoring division, one quotient bit per cycle.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (modulo 2^NBITS wrap, no trap).
- Divide by zero (DIV or DIVU with i_RT = 0):
  - Jump IDLE → FIX.
  - HI/LO are left unchanged.
  - o_done and o_div_zero pulse together.
- o_HI and o_LO are updated only at the FIX commit or by MTHI/MTLO. Partial results never appear on them.
- MTHI/MTLO:
  - Take effect only in IDLE with i_start low.
  - Both may be asserted in the same cycle; both writes take i_RS.
  - Ignored while busy.
- Priority when idle: i_start over i_MTHI/i_MTLO, which are then dropped.
- i_start while busy is ignored and not queued.
- Reset:
  - Any state goes to IDLE.
  - HI = LO = 0; o_busy = o_done = o_div_zero = 0.
  - An operation in progress is aborted with no o_done.

## Timing
- Reset values: o_HI = 0, o_LO = 0, o_busy = 0, o_done = 0, o_div_zero = 0.
- Edge 0: i_start sampled in IDLE. o_busy is high after edge 0.
- Edges 1..NBITS: CALC iterations.
- Edge NBITS+1: FIX; HI/LO commit.
  - After this edge, o_HI/o_LO hold the result, o_done = 1 for one cycle, and o_busy = 0.
  - Total latency is NBITS+1 edges (33 for NBITS = 32).
- The cycle in which o_done is high is IDLE, so a new i_start is accepted then (back-to-back operations).
- Divide by zero: edge 0 start, edge 1 FIX. After edge 1, o_done = o_div_zero = 1 and o_busy = 0.
- MTHI/MTLO: the new value is visible on o_HI/o_LO after the sampling edge (1-cycle latency).
- Operands are captured at edge 0. Changes on i_RS/i_RT after that have no effect.

## Test plan
- MULT i_RS = 0xFFFFFFFE, i_RT = 3 → o_done 33 edges after start; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. Also check that o_HI/o_LO hold their old values throughout busy.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Issue MULT 0xFFFFFFFF × 0xFFFFFFFF back-to-back in the o_done cycle → HI = 0, LO = 1.
- Normal divides:
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 2 → LO = 3, HI = 1.
  - DIV 7 / −2 → LO = 0xFFFFFFFD, HI = 1.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU 5 / 0 → o_done = o_div_zero = 1 one edge after the start edge; HI/LO unchanged.
- MTHI/MTLO gating:
  - MTHI 0x12345678 in IDLE → o_HI = 0x12345678 next cycle.
  - MTLO asserted while busy → ignored.
  - i_start during busy → ignored; exactly one o_done.
  - i_start with i_MTLO in IDLE → MTLO dropped.
- Reset mid-DIV: assert i_reset at edge 10 of a DIV → after that edge o_busy = 0, HI = LO = 0, and no o_done follows.

Source files
------------

// File: rtl/mult_div_hilo_if.sv
// Execute-stage bus between the pipeline and the multiply/divide HI/LO unit.
// slave : the unit (consumes start/op/operands/MT writes, drives HI/LO/status)
// master: the pipeline side driving operands and observing HI/LO/status
interface mult_div_hilo_if #(
    parameter int unsigned NBITS = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [NBITS-1:0] i_RS;
    logic [NBITS-1:0] i_RT;
    logic             i_MTHI;
    logic             i_MTLO;
    logic [NBITS-1:0] o_HI;
    logic [NBITS-1:0] o_LO;
    logic             o_busy;
    logic             o_done;
    logic             o_div_zero;

    modport slave (
        input  i_start, i_op, i_RS, i_RT, i_MTHI, i_MTLO,
        output o_HI, o_LO, o_busy, o_done, o_div_zero
    );

    modport master (
        output i_start, i_op, i_RS, i_RT, i_MTHI, i_MTLO,
        input  o_HI, o_LO, o_busy, o_done, o_div_zero
    );
endinterface

// File: rtl/mult_div_hilo.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix/commit.
// Ports:
//   i_clk    - clock, all state changes on the rising edge
//   i_reset  - synchronous active-high reset
//   bus      - slave side: i_start/i_op/i_RS/i_RT/i_MTHI/i_MTLO in,
//              o_HI/o_LO/o_busy/o_done/o_div_zero out (all registered)
module mult_div_hilo #(
    parameter int unsigned NBITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mult_div_hilo_if.slave        bus
);
    localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned AW = 2 * NBITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic [NBITS-1:0] m_q;        // multiplicand (mul) or divisor (div) magnitude
    logic [AW-1:0]    acc_q;      // product, or {remainder, dividend/quotient}
    logic             neg_q;      // product / quotient must be negated
    logic             rneg_q;     // remainder must be negated (dividend sign)
    logic             dz_pend_q;
    logic [NBITS-1:0] hi_q;
    logic [NBITS-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    // Operand magnitudes; op[0]=0 selects the signed variants
    logic             rs_neg_c, rt_neg_c;
    logic [NBITS-1:0] rs_mag_c, rt_mag_c;

    always_comb begin
        rs_neg_c = bus.i_RS[NBITS-1] & ~bus.i_op[0];
        rt_neg_c = bus.i_RT[NBITS-1] & ~bus.i_op[0];
        rs_mag_c = rs_neg_c ? NBITS'(NBITS'(0) - bus.i_RS) : bus.i_RS;
        rt_mag_c = rt_neg_c ? NBITS'(NBITS'(0) - bus.i_RT) : bus.i_RT;
    end

    // One iteration of either algorithm
    logic [NBITS:0]   mul_sum_c;
    logic [NBITS:0]   div_trial_c;
    logic [AW-1:0]    acc_next_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc_q[AW-1:NBITS]} + (acc_q[0] ? {1'b0, m_q} : (NBITS+1)'(0));
        // Partial remainder shifted left needs NBITS+1 bits before the trial subtract
        div_trial_c = acc_q[AW-1:NBITS-1] - {1'b0, m_q};
        if (op_q[1]) begin
            if (div_trial_c[NBITS]) begin
                acc_next_c = {acc_q[AW-2:0], 1'b0};
            end else begin
                acc_next_c = {div_trial_c[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};
            end
        end else begin
            acc_next_c = {mul_sum_c, acc_q[NBITS-1:1]};
        end
    end

    // Sign correction applied at commit
    logic [AW-1:0]    prod_c;
    logic [NBITS-1:0] quot_c;
    logic [NBITS-1:0] rem_c;

    always_comb begin
        prod_c = neg_q  ? AW'(AW'(0) - acc_q) : acc_q;
        quot_c = neg_q  ? NBITS'(NBITS'(0) - acc_q[NBITS-1:0]) : acc_q[NBITS-1:0];
        rem_c  = rneg_q ? NBITS'(NBITS'(0) - acc_q[AW-1:NBITS]) : acc_q[AW-1:NBITS];
    end

    // Control FSM, datapath and HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_pend_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        op_q   <= bus.i_op;
                        neg_q  <= rs_neg_c ^ rt_neg_c;
                        rneg_q <= rs_neg_c;
                        busy_q <= 1'b1;
                        if (bus.i_op[1]) begin
                            m_q   <= rt_mag_c;
                            acc_q <= {NBITS'(0), rs_mag_c};
                        end else begin
                            m_q   <= rs_mag_c;
                            acc_q <= {NBITS'(0), rt_mag_c};
                        end
                        if (bus.i_op[1] && (bus.i_RT == '0)) begin
                            dz_pend_q <= 1'b1;
                            state_q   <= ST_FIX;
                        end else begin
                            dz_pend_q <= 1'b0;
                            cnt_q     <= CW'(NBITS - 1);
                            state_q   <= ST_CALC;
                        end
                    end else begin
                        if (bus.i_MTHI) hi_q <= bus.i_RS;
                        if (bus.i_MTLO) lo_q <= bus.i_RS;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_next_c;
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_FIX: begin
                    if (!dz_pend_q) begin
                        if (op_q[1]) begin
                            hi_q <= rem_c;
                            lo_q <= quot_c;
                        end else begin
                            hi_q <= prod_c[AW-1:NBITS];
                            lo_q <= prod_c[NBITS-1:0];
                        end
                    end
                    done_q  <= 1'b1;
                    dz_q    <= dz_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_HI       = hi_q;
    assign bus.o_LO       = lo_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_hilo.sv
// Self-checking bench for mult_div_hilo: directed test-plan cases plus random
// operations compared against an arithmetic reference model of HI/LO.
module tb_mult_div_hilo;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_hilo_if #(.NBITS(N)) bus ();

    mult_div_hilo #(.NBITS(N)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO results from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [63:0] old);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = 64'(rs);
        ub = 64'(rt);
        res = old;
        case (op)
            2'd0: res = 64'(sa * sb);
            2'd1: res = ua * ub;
            2'd2: if (rt != 0) begin
                sq  = sa / sb;
                sr  = sa % sb;
                res = {sr[31:0], sq[31:0]};
            end
            default: if (rt != 0) begin
                uq  = ua / ub;
                ur  = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
        endcase
        return res;
    endfunction

    // Issue one operation from a negedge; returns at the negedge where o_done is seen
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input bit noise, input bit with_mtlo);
        logic [63:0] e;
        int n;
        bit dzexp;
        e     = model(op, rs, rt, {exp_hi, exp_lo});
        dzexp = op[1] && (rt == 0);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_RS    = rs;
        bus.i_RT    = rt;
        bus.i_MTLO  = with_mtlo;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_MTLO  = 1'b0;
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
        n = 0;
        while (!bus.o_done && n < 60) begin
            if (noise) begin
                bus.i_start = 1'($urandom);
                bus.i_MTHI  = 1'($urandom);
                bus.i_MTLO  = 1'($urandom);
            end
            bus.i_RS = $urandom;
            bus.i_RT = $urandom;
            chk({tag, "_holdhi"}, bus.o_HI, exp_hi);
            chk({tag, "_holdlo"}, bus.o_LO, exp_lo);
            @(negedge clk);
            n++;
        end
        bus.i_start = 1'b0;
        bus.i_MTHI  = 1'b0;
        bus.i_MTLO  = 1'b0;
        chk({tag, "_lat"}, 32'(n), dzexp ? 32'd1 : 32'd33);
        if (!dzexp) begin
            exp_hi = e[63:32];
            exp_lo = e[31:0];
        end
        chk({tag, "_hi"}, bus.o_HI, exp_hi);
        chk({tag, "_lo"}, bus.o_LO, exp_lo);
        chk({tag, "_dz"}, 32'(bus.o_div_zero), 32'(dzexp));
        chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
    endtask

    // Confirm done/div_zero stay low for a few cycles (single pulse, nothing queued)
    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.o_done || bus.o_div_zero || bus.o_busy) seen = 1'b1;
        end
        chk({tag, "_quiet"}, 32'(seen), 32'd0);
    endtask

    task automatic mt(input string tag, input bit hi, input bit lo, input logic [31:0] v);
        bus.i_MTHI = hi;
        bus.i_MTLO = lo;
        bus.i_RS   = v;
        @(negedge clk);
        bus.i_MTHI = 1'b0;
        bus.i_MTLO = 1'b0;
        bus.i_RS   = $urandom;
        if (hi) exp_hi = v;
        if (lo) exp_lo = v;
        chk({tag, "_hi"}, bus.o_HI, exp_hi);
        chk({tag, "_lo"}, bus.o_LO, exp_lo);
    endtask

    initial begin
        bit seen;
        logic [1:0] rop;
        logic [31:0] rrs, rrt;

        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_RS    = '0;
        bus.i_RT    = '0;
        bus.i_MTHI  = 1'b0;
        bus.i_MTLO  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi",   bus.o_HI, 32'd0);
        chk("rst_lo",   bus.o_LO, 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_dz",   32'(bus.o_div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MTHI/MTLO in idle, both together and individually
        mt("mt_both", 1'b1, 1'b1, 32'hA5A5_A5A5);
        mt("mthi", 1'b1, 1'b0, 32'h1234_5678);
        chk("mthi_const", bus.o_HI, 32'h1234_5678);
        mt("mtlo", 1'b0, 1'b1, 32'h0BAD_F00D);

        // MULT with busy-time noise: start/MTHI/MTLO must all be ignored
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        chk("mult_neg_hic", bus.o_HI, 32'hFFFF_FFFF);
        chk("mult_neg_loc", bus.o_LO, 32'hFFFF_FFFA);
        quiet("mult_neg", 40);

        // MULTU then MULT back-to-back in the done cycle
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hic", bus.o_HI, 32'hFFFF_FFFE);
        chk("multu_max_loc", bus.o_LO, 32'h0000_0001);
        run_op("mult_b2b", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("mult_b2b_hic", bus.o_HI, 32'h0);
        chk("mult_b2b_loc", bus.o_LO, 32'h1);
        quiet("mult_b2b", 3);

        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_m7_2_hic", bus.o_HI, 32'hFFFF_FFFF);
        chk("div_m7_2_loc", bus.o_LO, 32'hFFFF_FFFD);
        run_op("divu_7_2", 2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu_7_2_hic", bus.o_HI, 32'd1);
        chk("divu_7_2_loc", bus.o_LO, 32'd3);
        run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("div_7_m2_hic", bus.o_HI, 32'd1);
        chk("div_7_m2_loc", bus.o_LO, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_hic", bus.o_HI, 32'd0);
        chk("div_ovf_loc", bus.o_LO, 32'h8000_0000);
        quiet("div_ovf", 2);

        // Divide by zero leaves HI/LO intact
        mt("pre_dz", 1'b1, 1'b1, 32'hCAFE_0001);
        run_op("divu_zero", 2'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("divu_zero_loc", bus.o_LO, 32'hCAFE_0001);
        quiet("divu_zero", 3);

        // i_start with i_MTLO in idle: the MTLO is dropped
        run_op("start_mtlo_dz", 2'd2, 32'h5555_AAAA, 32'd0, 1'b0, 1'b1);
        chk("start_mtlo_dz_loc", bus.o_LO, 32'hCAFE_0001);
        run_op("start_mtlo_mul", 2'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        chk("start_mtlo_mul_loc", bus.o_LO, 32'd12);
        quiet("start_mtlo", 2);

        // Random operations and MT writes against the model
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom);
            rrs = $urandom;
            case ($urandom_range(0, 3))
                0: rrt = 32'($urandom_range(0, 3));
                1: rrt = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rrt = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                mt("rnd_mt", 1'($urandom), 1'($urandom), $urandom);
            end
            run_op("rnd", rop, rrs, rrt, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        quiet("rnd", 3);

        // Reset sampled at edge 10 of a DIV aborts it with no o_done
        bus.i_start = 1'b1;
        bus.i_op    = 2'd2;
        bus.i_RS    = 32'd1000;
        bus.i_RT    = 32'd7;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("rstdiv_busy", 32'(bus.o_busy), 32'd0);
        chk("rstdiv_hi", bus.o_HI, 32'd0);
        chk("rstdiv_lo", bus.o_LO, 32'd0);
        chk("rstdiv_done", 32'(bus.o_done), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        chk("rstdiv_nodone", 32'(seen), 32'd0);
        chk("rstdiv_hi_after", bus.o_HI, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
